// File: rtl/vram_pkg.sv
// vram_pkg: read-owner tags and default VRAM geometry shared by the arbiter and fetch pipelines
package vram_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;
  typedef enum logic [1:0] {OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU} owner_t;
endpackage

// File: rtl/vram_slot_arbiter_if.sv
// vram_slot_arbiter_if: requester handshakes plus the VRAM macro port seen by the arbiter
interface vram_slot_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);
  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic              bg_rvalid;
  logic [DATA_W-1:0] bg_rdata;
  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_ack;
  logic              spr_rvalid;
  logic [DATA_W-1:0] spr_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_timeout;
  modport master (
    output bg_req, bg_addr, spr_req, spr_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  bg_rvalid, bg_rdata, spr_ack, spr_rvalid, spr_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, cpu_timeout
  );
  modport slave (
    input  bg_req, bg_addr, spr_req, spr_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output bg_rvalid, bg_rdata, spr_ack, spr_rvalid, spr_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, cpu_timeout
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; req[1] may be forced to win with override
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       override,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic lastHi;
  logic pickHi;
  // on a tie the requester that did not win last time goes first
  always_comb begin
    pickHi = override | ~lastHi;
    gnt[1] = en & req[1] & (~req[0] | pickHi);
    gnt[0] = en & req[0] & (~req[1] | ~pickHi);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lastHi <= 1'b1;
    else if (|gnt) lastHi <= gnt[1];
endmodule

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: shares one VRAM port; background fetch is absolute, sprite/CPU round-robin
// with a CPU starvation override, and each read is tagged so its data returns to the right owner.
module vram_slot_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int CPU_WAIT_MAX = 24
) (
  input logic clk,
  input logic rst_n,
  vram_slot_arbiter_if.slave bus
);
  localparam int WAIT_W = $clog2(CPU_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_WAIT_MAX);
  logic [1:0]        gnt;
  owner_t            ownerQ, ownerD;
  logic [WAIT_W-1:0] cpuWaitQ, cpuWaitD;
  logic              cpuTimeoutQ;
  logic [ADDR_W-1:0] addrSel;
  logic [DATA_W-1:0] rdata;
  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (rst_n & ~bus.bg_req),
    .override (cpuWaitQ >= WAIT_MAX),
    .req      ({bus.cpu_req, bus.spr_req}),
    .gnt      (gnt)
  );
  always_comb begin
    addrSel       = bus.bg_req ? bus.bg_addr : gnt[0] ? bus.spr_addr : bus.cpu_addr;
    rdata         = bus.mem_rdata;
    bus.spr_ack   = gnt[0];
    bus.cpu_ack   = gnt[1];
    bus.mem_en    = rst_n & (bus.bg_req | (|gnt));
    bus.mem_we    = gnt[1] & bus.cpu_we;
    bus.mem_addr  = addrSel;
    bus.mem_wdata = bus.cpu_wdata;
    ownerD        = bus.bg_req ? OWN_BG : gnt[0] ? OWN_SPR : (gnt[1] & ~bus.cpu_we) ? OWN_CPU : OWN_NONE;
    cpuWaitD      = (!bus.cpu_req || gnt[1]) ? '0 : (cpuWaitQ == WAIT_MAX) ? WAIT_MAX : cpuWaitQ + 1'b1;
    bus.bg_rvalid  = ownerQ == OWN_BG;
    bus.spr_rvalid = ownerQ == OWN_SPR;
    bus.cpu_rvalid = ownerQ == OWN_CPU;
    bus.bg_rdata   = rdata;
    bus.spr_rdata  = rdata;
    bus.cpu_rdata  = rdata;
    bus.cpu_timeout = cpuTimeoutQ;
  end
  // reset drops any read still in flight, so no rvalid follows release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ownerQ      <= OWN_NONE;
      cpuWaitQ    <= '0;
      cpuTimeoutQ <= 1'b0;
    end else begin
      ownerQ      <= ownerD;
      cpuWaitQ    <= cpuWaitD;
      cpuTimeoutQ <= cpuTimeoutQ | (cpuWaitD == WAIT_MAX);
    end
endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Shares one single-port synchronous VRAM among three requesters: the background fetch pipeline, the sprite fetcher and the CPU.
- The background fetch pipeline has absolute priority, because its char and tile fetches are hard real-time within each 12-cycle tile slot.
- Sprite and CPU accesses use the remaining free cycles under round-robin.
- Sits between the requesters and the VRAM macro, and tags each issued read so that returned data goes to the correct requester.

Parameters:
- ADDR_W, 14, VRAM word address width.
- DATA_W, 8, VRAM data width.
- CPU_WAIT_MAX, 24, cycles a pending CPU request may wait before it takes priority over the sprite fetcher.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bg_req  in  1  background read request; single-cycle strobe, never stalled.
- bg_addr  in  ADDR_W  background read address.
- bg_rvalid  out  1  background read data valid.
- bg_rdata  out  DATA_W  background read data.
- spr_req  in  1  sprite read request, held until acknowledged.
- spr_addr  in  ADDR_W  sprite read address.
- spr_ack  out  1  sprite request issued this cycle.
- spr_rvalid  out  1  sprite read data valid.
- spr_rdata  out  DATA_W  sprite read data.
- cpu_req  in  1  CPU request, held until acknowledged.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  CPU request issued; for a write, the write is committed this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- mem_en  out  1  VRAM access enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid one cycle after the read is issued.
- cpu_timeout  out  1  sticky flag: CPU wait counter reached CPU_WAIT_MAX; cleared only by reset.

Behaviour:
- Grant logic is combinational in the request cycle; mem_* are driven in the same cycle as the grant.
- Priority order:
  - bg_req wins unconditionally.
  - Otherwise the round-robin between spr_req and cpu_req decides.
  - CPU override: if cpu_wait_q >= CPU_WAIT_MAX, CPU wins over sprite.
- Round-robin pointer rr_q holds the last winner among {SPR, CPU}. On a tie the other requester wins. rr_q updates only on an SPR or CPU grant. Reset value is CPU, so the sprite wins the first tie.
- spr_ack and cpu_ack pulse for exactly one cycle on grant. They are never asserted while the matching req is low, and never together, and never in a cycle with bg_req=1.
- Read return path:
  - owner_q is registered with values {NONE, BG, SPR, CPU}, and is set to NONE on writes and idle cycles.
  - Next cycle, <x>_rvalid = (owner_q == x) and <x>_rdata = mem_rdata.
  - Read latency is 1 cycle from grant for all requesters.
- Writes: CPU only. mem_we = cpu_we during a CPU grant; no rvalid is produced.
- cpu_wait_q:
  - Increments, saturating at CPU_WAIT_MAX, each cycle cpu_req=1 and cpu_ack=0.
  - Clears on cpu_ack or when cpu_req=0.
  - cpu_timeout sets when the counter reaches CPU_WAIT_MAX.
- Back-to-back bg_req, e.g. a full line of fetches, starves spr and cpu indefinitely. This is legal; requests remain pending and acks stay low.
- Requesters must hold req, addr, we and wdata stable until ack; the arbiter does not latch them.
- Reset values: rr_q = CPU, owner_q = NONE, cpu_wait_q = 0, cpu_timeout = 0. All acks, rvalids, mem_en and mem_we read 0 while rst_n = 0.
- Reset mid-operation: an outstanding read is dropped and no rvalid follows reset release.

Decomposition:
- Shared package vram_pkg holds:
  - owner_t enum {OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU};
  - default VRAM_ADDR_W = 14 and VRAM_DATA_W = 8, reused by the fetch pipelines.
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter with an override input, returning the grant one-hot and updating the last-winner pointer.

Test Plan:
- Lone CPU read, addr 0x0123, RAM preloaded with 0x5A -> cpu_ack in the request cycle; next cycle cpu_rvalid=1 and cpu_rdata=0x5A; bg_rvalid=0 and spr_rvalid=0.
- bg_req strobed on tile-slot cycles 0, 2 and 4 while cpu_req is held high -> cpu_ack is never coincident with bg_req; CPU is granted on cycle 1; bg_rvalid appears on cycles 1, 3 and 5.
- spr_req and cpu_req both held high, no bg, for 6 cycles -> grants alternate SPR, CPU, SPR, CPU, ..., starting with SPR after reset.
- bg_req held high for 30 cycles with cpu_req pending, CPU_WAIT_MAX=24 -> cpu_timeout sets at wait 24. After bg drops, with spr_req also pending, CPU wins first regardless of rr_q.
- CPU write 0xC3 to 0x0200, then CPU read of 0x0200 -> write has mem_we=1 and no rvalid; the read returns 0xC3.
- Assert rst_n=0 in the cycle after a sprite read grant -> spr_rvalid stays 0; after release all flags are clear and the first tie goes to the sprite.
